// File: rtl/word_select_pipe.sv
// word_select_pipe: registered N-to-1 word selector with a one-entry
// valid/ready output stage, a round-robin scan pointer and out-of-range
// select detection for channel counts that are not a power of two.
module word_select_pipe #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 32,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]          select,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      scan_clear,
    output logic [WIDTH-1:0]          out,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_error,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // One extra bit so CHANNELS itself is representable when it is 2**SEL_W.
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   out_r;
    logic [SEL_W-1:0]   out_channel_r;
    logic               out_error_r;
    logic [SEL_W-1:0]   scan_ptr_r;

    logic               accept_s;
    logic [SEL_W-1:0]   idx_s;
    logic               idx_err_s;
    logic [WIDTH-1:0]   sel_word_s;

    // The only combinational output path: a draining consumer frees the slot.
    assign in_ready    = (state_r == EMPTY) || out_ready;
    assign accept_s    = in_valid && in_ready;

    assign out         = out_r;
    assign out_channel = out_channel_r;
    assign out_error   = out_error_r;
    assign out_valid   = (state_r == FULL);

    // Pick the capture index and the word it addresses; an index past the
    // last channel matches no term of the OR-reduction and yields zero.
    always_comb begin
        idx_s      = mode ? scan_ptr_r : select;
        idx_err_s  = ({1'b0, idx_s} >= CH_LIMIT);
        sel_word_s = {WIDTH{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            sel_word_s = sel_word_s
                       | (data[k*WIDTH +: WIDTH] & {WIDTH{idx_s == SEL_W'(k)}});
        end
    end

    // Output stage FSM: capture on accept, drop to EMPTY on a drain without
    // a replacement, hold everything while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= EMPTY;
            out_r         <= {WIDTH{1'b0}};
            out_channel_r <= {SEL_W{1'b0}};
            out_error_r   <= 1'b0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) begin
                        state_r       <= FULL;
                        out_r         <= sel_word_s;
                        out_channel_r <= idx_s;
                        out_error_r   <= idx_err_s;
                    end else begin
                        state_r       <= EMPTY;
                    end
                end
                FULL: begin
                    if (accept_s) begin
                        state_r       <= FULL;
                        out_r         <= sel_word_s;
                        out_channel_r <= idx_s;
                        out_error_r   <= idx_err_s;
                    end else if (out_ready) begin
                        state_r       <= EMPTY;
                    end else begin
                        state_r       <= FULL;
                    end
                end
                default: begin
                    state_r       <= EMPTY;
                    out_r         <= {WIDTH{1'b0}};
                    out_channel_r <= {SEL_W{1'b0}};
                    out_error_r   <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin scan pointer: clear wins over advance, and it wraps at the
    // last real channel so scan mode can never produce an out-of-range index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_ptr_r <= {SEL_W{1'b0}};
        end else if (scan_clear) begin
            scan_ptr_r <= {SEL_W{1'b0}};
        end else if (accept_s && mode) begin
            if (scan_ptr_r == PTR_LAST) begin
                scan_ptr_r <= {SEL_W{1'b0}};
            end else begin
                scan_ptr_r <= scan_ptr_r + {{(SEL_W-1){1'b0}}, 1'b1};
            end
        end else begin
            scan_ptr_r <= scan_ptr_r;
        end
    end

endmodule

// File: tb/tb_word_select_pipe.sv
// Directed bench for word_select_pipe: a 32-channel instance for the direct,
// backpressure and drain/accept cases and a 5-channel instance for scan
// wrap and out-of-range selects; both share clock and reset.
module tb_word_select_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 32-channel instance
    logic [32*32-1:0] data32;
    logic [4:0]       sel32;
    logic             mode32, in_valid32, in_ready32, scan_clear32;
    logic [31:0]      out32;
    logic [4:0]       ch32;
    logic             err32, valid32, out_ready32;

    // 5-channel instance
    logic [5*32-1:0]  data5;
    logic [2:0]       sel5;
    logic             mode5, in_valid5, in_ready5, scan_clear5;
    logic [31:0]      out5;
    logic [2:0]       ch5;
    logic             err5, valid5, out_ready5;

    int errors = 0;
    int checks = 0;

    word_select_pipe #(.WIDTH(32), .CHANNELS(32)) u32 (
        .clk(clk), .reset_n(rst_n), .data(data32), .select(sel32),
        .mode(mode32), .in_valid(in_valid32), .in_ready(in_ready32),
        .scan_clear(scan_clear32), .out(out32), .out_channel(ch32),
        .out_error(err32), .out_valid(valid32), .out_ready(out_ready32)
    );

    word_select_pipe #(.WIDTH(32), .CHANNELS(5)) u5 (
        .clk(clk), .reset_n(rst_n), .data(data5), .select(sel5),
        .mode(mode5), .in_valid(in_valid5), .in_ready(in_ready5),
        .scan_clear(scan_clear5), .out(out5), .out_channel(ch5),
        .out_error(err5), .out_valid(valid5), .out_ready(out_ready5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill32(input logic [31:0] base);
        for (int k = 0; k < 32; k++) data32[k*32 +: 32] = base + 32'(k);
    endtask

    initial begin
        rst_n = 1'b0;
        fill32(32'hA000_0000);
        for (int k = 0; k < 5; k++) data5[k*32 +: 32] = 32'hB000_0000 + 32'(k);
        sel32 = 5'd0; mode32 = 1'b0; in_valid32 = 1'b0; scan_clear32 = 1'b0; out_ready32 = 1'b1;
        sel5  = 3'd0; mode5  = 1'b0; in_valid5  = 1'b0; scan_clear5  = 1'b0; out_ready5  = 1'b1;
        #23;
        chk("reset_valid",  {63'd0, valid32}, 64'd0);
        chk("reset_out",    {32'd0, out32},   64'd0);
        chk("reset_ch",     {59'd0, ch32},    64'd0);
        chk("reset_err",    {63'd0, err32},   64'd0);
        chk("reset_ready",  {63'd0, in_ready32}, 64'd1);
        rst_n = 1'b1;
        step();

        // Direct sweep, back to back
        for (int k = 0; k < 32; k++) begin
            sel32 = 5'(k); in_valid32 = 1'b1;
            step();
            chk("sweep_valid", {63'd0, valid32}, 64'd1);
            chk("sweep_out",   {32'd0, out32},   {32'd0, 32'hA000_0000 + 32'(k)});
            chk("sweep_ch",    {59'd0, ch32},    64'(k));
        end
        in_valid32 = 1'b0;
        step();
        chk("drain_empty", {63'd0, valid32}, 64'd0);

        // Backpressure
        sel32 = 5'd7; in_valid32 = 1'b1;
        step();
        chk("bp_first", {32'd0, out32}, {32'd0, 32'hA000_0007});
        out_ready32 = 1'b0; sel32 = 5'd9;
        fill32(32'hA100_0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_inready", {63'd0, in_ready32}, 64'd0);
            step();
            chk("bp_hold_out",   {32'd0, out32},   {32'd0, 32'hA000_0007});
            chk("bp_hold_ch",    {59'd0, ch32},    64'd7);
            chk("bp_hold_valid", {63'd0, valid32}, 64'd1);
        end
        out_ready32 = 1'b1;
        step();
        chk("bp_release_out", {32'd0, out32}, {32'd0, 32'hA100_0009});
        chk("bp_release_ch",  {59'd0, ch32},  64'd9);
        in_valid32 = 1'b0;
        step();

        // Simultaneous drain and accept
        fill32(32'hA000_0000);
        sel32 = 5'd5; in_valid32 = 1'b1;
        step();
        sel32 = 5'd3;
        #1;
        chk("da_inready", {63'd0, in_ready32}, 64'd1);
        step();
        chk("da_valid", {63'd0, valid32}, 64'd1);
        chk("da_out",   {32'd0, out32},   {32'd0, 32'hA000_0003});
        in_valid32 = 1'b0;
        step();

        // Scan wrap on 5 channels
        mode5 = 1'b1; in_valid5 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("scan_ch",  {61'd0, ch5},  64'(i % 5));
            chk("scan_out", {32'd0, out5}, {32'd0, 32'hB000_0000 + 32'(i % 5)});
            chk("scan_err", {63'd0, err5}, 64'd0);
        end
        scan_clear5 = 1'b1;
        step();
        chk("scan_clr_same", {61'd0, ch5}, 64'd2);
        scan_clear5 = 1'b0;
        step();
        chk("scan_clr_next", {61'd0, ch5}, 64'd0);

        // Out-of-range select
        mode5 = 1'b0; sel5 = 3'd6;
        step();
        chk("oor_out", {32'd0, out5}, 64'd0);
        chk("oor_err", {63'd0, err5}, 64'd1);
        chk("oor_ch",  {61'd0, ch5},  64'd6);
        sel5 = 3'd4;
        step();
        chk("inr_err", {63'd0, err5}, 64'd0);
        chk("inr_out", {32'd0, out5}, {32'd0, 32'hB000_0004});

        // Async reset while both are FULL (u5 scan pointer is 1 here)
        in_valid5 = 1'b0; out_ready5 = 1'b0;
        sel32 = 5'd10; in_valid32 = 1'b1;
        step();
        in_valid32 = 1'b0; out_ready32 = 1'b0;
        chk("pre_rst_valid", {63'd0, valid32}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid32", {63'd0, valid32}, 64'd0);
        chk("arst_out32",   {32'd0, out32},   64'd0);
        chk("arst_ch32",    {59'd0, ch32},    64'd0);
        chk("arst_valid5",  {63'd0, valid5},  64'd0);
        chk("arst_ready32", {63'd0, in_ready32}, 64'd1);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", {63'd0, valid32}, 64'd0);
        chk("post_rst_ready", {63'd0, in_ready32}, 64'd1);
        out_ready5 = 1'b1; mode5 = 1'b1; in_valid5 = 1'b1;
        step();
        chk("post_rst_ptr", {61'd0, ch5}, 64'd0);
        in_valid5 = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
